// File: rtl/cdc_xfer_scheduler_if.sv
// cdc_xfer_scheduler_if: requester-side and transfer-path signals of the scheduler.
// master = requesters + ack synchronizer side; slave = scheduler.
// Signals:
//   req_i/data_i      channel requests and their words
//   done_o/err_o      per-channel completion / timeout pulses
//   busy_o            scheduler not idle
//   xfer_flag_o       launch pulse into the flag synchronizer
//   xfer_chan_o/data_o granted channel and its latched word
//   xfer_ack_i        ack pulse, already synchronized to clk
interface cdc_xfer_scheduler_if #(
   parameter int NCH   = 4,
   parameter int WIDTH = 32
);
   localparam int CW = $clog2(NCH);

   logic [NCH-1:0]       req_i;
   logic [NCH*WIDTH-1:0] data_i;
   logic [NCH-1:0]       done_o;
   logic [NCH-1:0]       err_o;
   logic                 busy_o;
   logic                 xfer_flag_o;
   logic [CW-1:0]        xfer_chan_o;
   logic [WIDTH-1:0]     xfer_data_o;
   logic                 xfer_ack_i;

   modport master (
      output req_i, data_i, xfer_ack_i,
      input  done_o, err_o, busy_o,
      input  xfer_flag_o, xfer_chan_o, xfer_data_o
   );

   modport slave (
      input  req_i, data_i, xfer_ack_i,
      output done_o, err_o, busy_o,
      output xfer_flag_o, xfer_chan_o, xfer_data_o
   );
endinterface

// File: rtl/cdc_xfer_scheduler.sv
// cdc_xfer_scheduler: round-robin arbiter for a single flag-synchronized CDC slot.
// One transfer in flight, holdoff after each transfer, ack timeout.
// Ports:
//   clk    single clock
//   rst_n  synchronous active-low reset
//   bus    slave side of cdc_xfer_scheduler_if (requests, results, transfer path)
module cdc_xfer_scheduler #(
   parameter int NCH     = 4,
   parameter int WIDTH   = 32,
   parameter int HOLDOFF = 3,
   parameter int TIMEOUT = 255
) (
   input logic                clk,
   input logic                rst_n,
   cdc_xfer_scheduler_if.slave bus
);
   localparam int CW = $clog2(NCH);
   localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF - 1);
   localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_ACK,
      HOLD
   } state_t;

   state_t        state;
   logic [CW-1:0] ptr;
   logic [7:0]    timer;
   logic [3:0]    holdCnt;

   logic [CW-1:0] grantIdx;
   logic          grantVld;
   logic [CW-1:0] cand;
   logic          tmoHit;

   // Scan from ptr upward with wrap; walking k downward lets the
   // nearest candidate overwrite the farther ones.
   always_comb begin
      grantIdx = '0;
      grantVld = 1'b0;
      cand     = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         cand = CW'((int'(ptr) + k) % NCH);
         if (bus.req_i[cand]) begin
            grantVld = 1'b1;
            grantIdx = cand;
         end
      end
   end

   assign tmoHit = (TIMEOUT != 0) && (timer == TMO_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         ptr             <= '0;
         timer           <= '0;
         holdCnt         <= '0;
         bus.done_o      <= '0;
         bus.err_o       <= '0;
         bus.busy_o      <= 1'b0;
         bus.xfer_flag_o <= 1'b0;
         bus.xfer_chan_o <= '0;
         bus.xfer_data_o <= '0;
      end else begin
         bus.xfer_flag_o <= 1'b0;
         bus.done_o      <= '0;
         bus.err_o       <= '0;
         case (state)
            IDLE: begin
               if (grantVld) begin
                  state           <= LAUNCH;
                  bus.busy_o      <= 1'b1;
                  bus.xfer_flag_o <= 1'b1;
                  bus.xfer_chan_o <= grantIdx;
                  bus.xfer_data_o <= bus.data_i[int'(grantIdx)*WIDTH +: WIDTH];
                  ptr <= (grantIdx == CW'(NCH - 1)) ? '0 : grantIdx + 1'b1;
               end
            end
            LAUNCH: begin
               timer <= '0;
               state <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (timer != 8'hFF) timer <= timer + 8'd1;
               // Ack takes priority over a coinciding timeout.
               if (bus.xfer_ack_i) begin
                  bus.done_o <= NCH'(1) << bus.xfer_chan_o;
                  holdCnt    <= HOLD_INIT;
                  state      <= HOLD;
               end else if (tmoHit) begin
                  bus.err_o  <= NCH'(1) << bus.xfer_chan_o;
                  holdCnt    <= HOLD_INIT;
                  state      <= HOLD;
               end
            end
            HOLD: begin
               if (holdCnt == 4'd0) begin
                  state      <= IDLE;
                  bus.busy_o <= 1'b0;
               end else begin
                  holdCnt <= holdCnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cdc_xfer_scheduler.sv
// tb_cdc_xfer_scheduler: vector table plus scoreboard for cdc_xfer_scheduler.
// Launches are checked against a queue of expected grants.
module tb_cdc_xfer_scheduler;
   localparam int NCH = 4;
   localparam int WIDTH = 32;
   localparam int HOLDOFF = 3;
   localparam int TMO = 255;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   cdc_xfer_scheduler_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();

   cdc_xfer_scheduler #(
      .NCH(NCH), .WIDTH(WIDTH), .HOLDOFF(HOLDOFF), .TIMEOUT(TMO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   typedef struct {
      logic [3:0] req;
      int         dly;
      int         chan;
      logic [3:0] done;
      logic [3:0] err;
      bit         stray;
   } vec_t;

   typedef struct {
      int          chan;
      logic [31:0] data;
   } exp_t;

   int total = 0;
   int bad = 0;
   exp_t expQ[$];
   logic [31:0] words[NCH];
   vec_t tbl[14];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [43:0] allOut();
      return {bus.busy_o, bus.xfer_flag_o, bus.xfer_chan_o,
              bus.xfer_data_o, bus.done_o, bus.err_o};
   endfunction

   always @(negedge clk) begin
      if (bus.xfer_flag_o) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sbEmpty: got flag chan=%0d want none",
                     bus.xfer_chan_o);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            chk("sbChan", 64'(bus.xfer_chan_o), 64'(e.chan));
            chk("sbData", 64'(bus.xfer_data_o), 64'(e.data));
         end
      end
   end

   task automatic pushExp(input int ch);
      exp_t e;
      e.chan = ch;
      e.data = words[ch];
      expQ.push_back(e);
   endtask

   task automatic waitFlag(output bit seen);
      int n;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         seen = bus.xfer_flag_o;
      end
      chk("flagSeen", 64'(seen), 64'd1);
   endtask

   // dly<0: no ack, expect timeout. Returns on the IDLE re-entry cycle.
   task automatic doXfer(input int dly, input int ch,
                         input logic [3:0] eDone, input logic [3:0] eErr,
                         input bit stray);
      bit seen;
      bit early;
      int r;
      waitFlag(seen);
      if (!seen) return;
      chk("busyLaunch", 64'(bus.busy_o), 64'd1);
      r = (dly >= 0) ? dly + 1 : TMO + 1;
      early = 1'b0;
      for (int c = 1; c < r; c++) begin
         @(negedge clk);
         if (bus.done_o != 0 || bus.err_o != 0) early = 1'b1;
         if (c == 1) chk("flagOnce", 64'(bus.xfer_flag_o), 64'd0);
         bus.xfer_ack_i = (dly >= 0 && c == dly);
      end
      @(negedge clk);
      bus.xfer_ack_i = 1'b0;
      chk("noEarly", 64'(early), 64'd0);
      chk("done", 64'(bus.done_o), 64'(eDone));
      chk("err", 64'(bus.err_o), 64'(eErr));
      @(negedge clk);
      chk("pulseOnce", 64'({bus.done_o, bus.err_o}), 64'd0);
      if (stray) bus.xfer_ack_i = 1'b1;
      @(negedge clk);
      bus.xfer_ack_i = 1'b0;
      chk("busyHold", 64'(bus.busy_o), 64'd1);
      if (stray)
         chk("strayHold", 64'({bus.done_o, bus.err_o}), 64'd0);
      @(negedge clk);
      chk("idleBack", 64'(bus.busy_o), 64'd0);
      chk("chanHold", 64'(bus.xfer_chan_o), 64'(ch));
   endtask

   initial begin
      bit seen;
      words[0] = 32'h1111_0000;
      words[1] = 32'h2222_1111;
      words[2] = 32'hDEAD_BEEF;
      words[3] = 32'hC0FF_EE33;

      tbl[0]  = '{4'b0100, 5,   2, 4'b0100, 4'b0000, 1'b0};
      tbl[1]  = '{4'b1000, 2,   3, 4'b1000, 4'b0000, 1'b0};
      tbl[2]  = '{4'b1111, 2,   0, 4'b0001, 4'b0000, 1'b0};
      tbl[3]  = '{4'b1111, 2,   1, 4'b0010, 4'b0000, 1'b0};
      tbl[4]  = '{4'b1111, 2,   2, 4'b0100, 4'b0000, 1'b0};
      tbl[5]  = '{4'b1111, 2,   3, 4'b1000, 4'b0000, 1'b0};
      tbl[6]  = '{4'b1111, 2,   0, 4'b0001, 4'b0000, 1'b0};
      tbl[7]  = '{4'b0001, 3,   0, 4'b0001, 4'b0000, 1'b1};
      tbl[8]  = '{4'b0110, 2,   1, 4'b0010, 4'b0000, 1'b0};
      tbl[9]  = '{4'b1001, 4,   3, 4'b1000, 4'b0000, 1'b0};
      tbl[10] = '{4'b0111, -1,  0, 4'b0000, 4'b0001, 1'b0};
      tbl[11] = '{4'b0111, 2,   1, 4'b0010, 4'b0000, 1'b0};
      tbl[12] = '{4'b0111, 2,   2, 4'b0100, 4'b0000, 1'b0};
      tbl[13] = '{4'b0111, TMO, 0, 4'b0001, 4'b0000, 1'b0};

      rst_n = 1'b0;
      bus.req_i = '0;
      bus.xfer_ack_i = 1'b0;
      bus.data_i = {words[3], words[2], words[1], words[0]};
      repeat (3) @(negedge clk);
      chk("resetState", 64'(allOut()), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         bus.req_i = tbl[i].req;
         pushExp(tbl[i].chan);
         doXfer(tbl[i].dly, tbl[i].chan, tbl[i].done, tbl[i].err,
                tbl[i].stray);
      end

      // Stray ack with nothing pending in IDLE.
      bus.req_i = '0;
      @(negedge clk);
      bus.xfer_ack_i = 1'b1;
      @(negedge clk);
      bus.xfer_ack_i = 1'b0;
      chk("strayIdle1", 64'({bus.busy_o, bus.xfer_flag_o,
                             bus.done_o, bus.err_o}), 64'd0);
      @(negedge clk);
      chk("strayIdle2", 64'({bus.busy_o, bus.xfer_flag_o,
                             bus.done_o, bus.err_o}), 64'd0);

      // Reset while waiting for ack; ptr was advanced to 2 before it.
      bus.req_i = 4'b0010;
      pushExp(1);
      waitFlag(seen);
      @(negedge clk);
      rst_n = 1'b0;
      bus.req_i = '0;
      @(negedge clk);
      chk("rstMid", 64'(allOut()), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      bus.xfer_ack_i = 1'b1;
      @(negedge clk);
      bus.xfer_ack_i = 1'b0;
      chk("rstStray1", 64'(allOut()), 64'd0);
      @(negedge clk);
      chk("rstStray2", 64'(allOut()), 64'd0);
      bus.req_i = 4'b1010;
      pushExp(1);
      doXfer(2, 1, 4'b0010, 4'b0000, 1'b0);
      bus.req_i = '0;
      repeat (2) @(negedge clk);
      chk("sbDrained", 64'(expQ.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
